// File: rtl/ifu_pkg.sv
// Shared defaults and helpers for the instruction fetch unit and its prefetch queue.
package ifu_pkg;

  localparam int          IFU_XLEN         = 32;
  localparam int          IFU_ILEN         = 32;
  localparam int          IFU_QDEPTH       = 4;
  localparam logic [31:0] IFU_RESET_VECTOR = 32'h0000_0000;

  // Width of a counter that must hold every value from 0 up to and including depth.
  function automatic int ifu_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Instruction-memory request/response port and decode-side valid/ready port of the fetch unit.
interface ifu_imem_if #(
  parameter int XLEN = ifu_pkg::IFU_XLEN,
  parameter int ILEN = ifu_pkg::IFU_ILEN
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [ILEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

interface ifu_dec_if #(
  parameter int XLEN = ifu_pkg::IFU_XLEN,
  parameter int ILEN = ifu_pkg::IFU_ILEN
);
  logic            valid;
  logic            ready;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] pc;

  modport master (output valid, instr, pc, input ready);
  modport slave  (input valid, instr, pc, output ready);
endinterface

// File: rtl/ifu_fifo.sv
// In-order instruction queue: registered storage, head always visible, flush wins over push/pop.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int  DEPTH = IFU_QDEPTH,
  parameter int  WIDTH = IFU_ILEN,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = ifu_cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy lives in count, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  a_no_push_full : assert property (@(posedge clk) disable iff (reset)
    (push && !flush) |-> (count != CNT_W'(DEPTH)));

  a_no_pop_empty : assert property (@(posedge clk) disable iff (reset)
    (pop && !flush) |-> (count != '0));

endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: credit-limited memory requests, in-order queue to decode,
// redirect flushes the queue and marks every in-flight response as stale.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int              XLEN         = IFU_XLEN,
  parameter int              ILEN         = IFU_ILEN,
  parameter int              QDEPTH       = IFU_QDEPTH,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(IFU_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  ifu_imem_if.master      imem,
  ifu_dec_if.master       dec
);

  localparam int              CNT_W   = ifu_cnt_width(QDEPTH);
  localparam logic [CNT_W:0]  CREDITS = (CNT_W+1)'(QDEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  fetch_pc_nxt;
  logic [XLEN-1:0]  deq_pc;
  logic [XLEN-1:0]  deq_pc_nxt;
  logic [XLEN-1:0]  redirect_target;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] discard_nxt;
  logic [CNT_W:0]   credits_used;
  logic             granted;
  logic             push;
  logic             pop;
  logic             unused_pc_lsbs;

  assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_pc_lsbs  = ^redirect_pc_i[1:0];

  // Every queued entry and every granted-but-unanswered request holds one queue slot,
  // so a returning response can never find the queue full.
  assign credits_used = {1'b0, count} + {1'b0, outstanding};
  assign imem.req     = !reset && fetch_en_i && (credits_used < CREDITS);
  assign imem.addr    = fetch_pc;
  assign granted      = imem.req && imem.gnt;

  assign push      = imem.rvalid && (discard == '0) && !redirect_i;
  assign dec.valid = (count != '0);
  assign pop       = dec.valid && dec.ready;
  assign dec.pc    = deq_pc;

  ifu_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ILEN)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_i),
    .push      (push),
    .push_data (imem.rdata),
    .pop       (pop),
    .count     (count),
    .head      (dec.instr)
  );

  // NOTE: every signal written here gets a default first so no path leaves a latch.
  always_comb begin
    fetch_pc_nxt    = fetch_pc;
    deq_pc_nxt      = deq_pc;
    outstanding_nxt = outstanding + CNT_W'(granted) - CNT_W'(imem.rvalid);
    discard_nxt     = discard;

    if (imem.rvalid && (discard != '0)) discard_nxt = discard - CNT_W'(1);
    if (granted)                         fetch_pc_nxt = fetch_pc + XLEN'(4);
    if (pop)                             deq_pc_nxt   = deq_pc + XLEN'(4);

    // Whatever is still in flight after this edge, including a grant taken this cycle, is stale.
    if (redirect_i) begin
      fetch_pc_nxt = redirect_target;
      deq_pc_nxt   = redirect_target;
      discard_nxt  = outstanding_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_VECTOR;
      deq_pc      <= RESET_VECTOR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      deq_pc      <= deq_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  a_rvalid_has_request : assert property (@(posedge clk) disable iff (reset)
    imem.rvalid |-> (outstanding != '0));

  a_discard_bounded : assert property (@(posedge clk) disable iff (reset)
    discard <= outstanding);

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: directed vector table, corner sequences, then random
// traffic against a queue-based model of memory, in-flight requests and the decode stream.
module tb_ifu_prefetch;
  import ifu_pkg::*;

  localparam int XLEN   = 32;
  localparam int ILEN   = 32;
  localparam int QDEPTH = 4;

  typedef struct {
    logic [31:0] addr;   // address the DUT put on the bus (selects returned data)
    logic [31:0] pc;     // address the model expects this request to carry
    bit          stale;
    int          due;
  } pend_t;

  typedef struct {
    bit          rst;
    bit          fe;
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          gnt;
    bit          rv;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  ifu_imem_if #(.XLEN(XLEN), .ILEN(ILEN)) imem ();
  ifu_dec_if  #(.XLEN(XLEN), .ILEN(ILEN)) dec ();

  ifu_prefetch #(
    .XLEN         (XLEN),
    .ILEN         (ILEN),
    .QDEPTH       (QDEPTH),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en_i    (fetch_en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (imem),
    .dec           (dec)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  pend_t       pend_q[$];
  logic [31:0] stream_q[$];
  logic [31:0] exp_fetch_pc = 32'h0;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;
  vec_t        vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic vec_t mk(input bit rst, fe, rdy, redir, input logic [31:0] rpc,
                              input bit gnt, rv, exp_req, input logic [31:0] exp_addr,
                              input bit exp_valid, input logic [31:0] exp_pc);
    vec_t r;
    r = '{rst: rst, fe: fe, rdy: rdy, redir: redir, rpc: rpc, gnt: gnt, rv: rv,
          exp_req: exp_req, exp_addr: exp_addr, exp_valid: exp_valid, exp_pc: exp_pc};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One reset cycle; in-flight requests are forgotten by memory too.
  task automatic do_reset();
    #1;
    reset = 1'b1; fetch_en = 1'b1; redirect = 1'b0; dec.ready = 1'b1;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
    #1;
    check("req_in_reset", imem.req, 1'b0);
    pend_q.delete();
    stream_q.delete();
    exp_fetch_pc = 32'h0;
    @(posedge clk);
    cyc++;
  endtask

  // One clock: drive inputs, compare the DUT against the model, then advance the model.
  task automatic cycle(input bit fe, rdy, redir, input logic [31:0] rpc, input bit gnt_req, rv_req);
    pend_t head;
    bit    m_rv, m_gnt, exp_req;
    #1;
    reset = 1'b0; fetch_en = fe; dec.ready = rdy; redirect = redir; redirect_pc = rpc;
    imem.gnt = 1'b0;
    m_rv = rv_req && (pend_q.size() != 0) && (pend_q[0].due <= cyc);
    imem.rvalid = m_rv;
    imem.rdata  = m_rv ? instr_of(pend_q[0].addr) : '0;
    #1;
    s_req = imem.req; s_addr = imem.addr;
    s_valid = dec.valid; s_pc = dec.pc; s_instr = dec.instr;

    exp_req = fe && (stream_q.size() + pend_q.size() < QDEPTH);
    check("req", s_req, exp_req);
    if (exp_req) check("addr", s_addr, exp_fetch_pc);
    check("valid", s_valid, stream_q.size() != 0);
    if (stream_q.size() != 0) begin
      check("pc", s_pc, stream_q[0]);
      check("instr", s_instr, instr_of(stream_q[0]));
    end

    m_gnt = gnt_req && s_req;
    imem.gnt = m_gnt;

    if ((stream_q.size() != 0) && rdy) void'(stream_q.pop_front());
    if (m_rv) begin
      head = pend_q.pop_front();
      if (!head.stale && !redir) stream_q.push_back(head.pc);
    end
    if (m_gnt) begin
      pend_q.push_back('{addr: s_addr, pc: exp_fetch_pc, stale: 1'b0, due: cyc + mem_lat});
      exp_fetch_pc += 32'd4;
    end
    if (redir) begin
      stream_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      exp_fetch_pc = {rpc[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0; dec.ready = 1'b0;

    // rst fe rdy redir rpc gnt rv | req addr valid pc
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 32'h00, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 32'h00, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 32'h04, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 32'h08, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 32'h0C, 1, 32'h4));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 32'h10, 1, 32'h8));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 32'h00, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 32'h00, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 32'h04, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 32'h08, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 32'h0C, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 32'h00, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 32'h00, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 32'h00, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, 32'h10, 1, 32'h4));

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
        continue;
      end
      cycle(vecs[i].fe, vecs[i].rdy, vecs[i].redir, vecs[i].rpc, vecs[i].gnt, vecs[i].rv);
      check($sformatf("vec%0d_req", i), s_req, vecs[i].exp_req);
      if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), s_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_pc", i), s_pc, vecs[i].exp_pc);
    end

    // Redirect to an unaligned target with two requests in flight.
    mem_lat = 2;
    repeat (6) cycle(1, 1, 0, 0, 1, 1);
    cycle(1, 1, 1, 32'h103, 0, 0);
    cycle(1, 1, 0, 0, 1, 1);
    check("redir_valid_next", s_valid, 1'b0);
    check("redir_req_next", s_req, 1'b1);
    check("redir_addr_next", s_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1, 1, 0, 0, 1, 1);
      found = s_valid;
    end
    check("redir_out_seen", found, 1'b1);
    check("redir_first_pc", s_pc, 32'h100);
    check("redir_first_instr", s_instr, instr_of(32'h100));

    // Redirect coinciding with a grant and a response.
    mem_lat = 1;
    repeat (4) cycle(1, 1, 0, 0, 1, 1);
    cycle(1, 1, 1, 32'h200, 1, 1);
    cycle(1, 1, 0, 0, 1, 1);
    check("same_cyc_valid_next", s_valid, 1'b0);
    check("same_cyc_addr_next", s_addr, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1, 1, 0, 0, 1, 1);
      found = s_valid;
    end
    check("same_cyc_out_seen", found, 1'b1);
    check("same_cyc_first_pc", s_pc, 32'h200);

    // Fetch address wraps past the top of the address space.
    cycle(1, 1, 1, 32'hFFFF_FFFE, 0, 0);
    cycle(1, 1, 0, 0, 1, 1);
    check("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
    cycle(1, 1, 0, 0, 1, 1);
    check("wrap_addr_zero", s_addr, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1, 1, 0, 0, 1, 1);
      found = s_valid;
    end
    check("wrap_out_seen", found, 1'b1);
    check("wrap_pc_top", s_pc, 32'hFFFF_FFFC);
    cycle(1, 1, 0, 0, 1, 1);
    check("wrap_pc_zero", s_pc, 32'h0);

    // fetch_en low: no new requests, in-flight responses still land in the queue.
    repeat (6) cycle(0, 0, 0, 0, 1, 1);

    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) do_reset();
      mem_lat = $urandom_range(1, 4);
      cycle(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 50) == 0, $urandom,
            ($urandom % 3) != 0, ($urandom % 4) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
